// File: rtl/banco_registros_param.sv
// Multi-port register file with synchronous write, combinational reads, optional bypass and zero register.
// Latency: reads are combinational; writes become visible one cycle later, or in the same cycle when bypass is on.
// Backpressure: none; while the bulk-clear engine is busy, writes are discarded and flagged on wr_drop.
module banco_registros_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   ra,
    output logic [NUM_RD*DATA_W-1:0]   dr,
    input  logic [ADDR_W-1:0]          dir,
    input  logic [DATA_W-1:0]          di,
    input  logic                       reg_write,
    input  logic                       clr_req,
    output logic                       clr_busy,
    output logic                       clr_done,
    output logic                       wr_drop
);

    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   clr_idx_q;
    logic                clr_busy_q;
    logic                clr_done_q;
    logic [DATA_W-1:0]   regs_q [DEPTH];

    logic                wr_zero;
    logic                wr_acc;

    // A write to register 0 is meaningless when it is hardwired to zero.
    assign wr_zero  = (ZERO_REG != 0) && (dir == '0);
    // The clear engine owns the array while busy, so host writes lose arbitration.
    assign wr_acc   = reg_write && !clr_busy_q && !wr_zero;
    assign wr_drop  = reg_write && (clr_busy_q || wr_zero);
    assign clr_busy = clr_busy_q;
    assign clr_done = clr_done_q;

    // Clear sequencer: walks every index once, then gives a one-cycle done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            clr_idx_q  <= '0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    clr_done_q <= 1'b0;
                    if (clr_req) begin
                        state_q    <= S_CLEAR;
                        clr_idx_q  <= '0;
                        clr_busy_q <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (clr_idx_q == LAST_IDX) begin
                        state_q    <= S_DONE;
                        clr_idx_q  <= '0;
                        clr_busy_q <= 1'b0;
                        clr_done_q <= 1'b1;
                    end else begin
                        clr_idx_q  <= clr_idx_q + ADDR_W'(1);
                    end
                end
                S_DONE: begin
                    state_q    <= S_IDLE;
                    clr_done_q <= 1'b0;
                end
                default: begin
                    state_q    <= S_IDLE;
                    clr_idx_q  <= '0;
                    clr_busy_q <= 1'b0;
                    clr_done_q <= 1'b0;
                end
            endcase
        end
    end

    // One storage flop per register; the clear engine and the host write port are mutually exclusive.
    for (genvar r = 0; r < DEPTH; r++) begin : g_reg
        // Register r: async zero, cleared when the engine reaches it, else loaded on an accepted write.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                regs_q[r] <= '0;
            end else if (clr_busy_q && (clr_idx_q == ADDR_W'(r))) begin
                regs_q[r] <= '0;
            end else if (wr_acc && (dir == ADDR_W'(r))) begin
                regs_q[r] <= di;
            end
        end
    end

    // Independent combinational read ports.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] rd_addr;
        logic [DATA_W-1:0] rd_dat;

        assign rd_addr = ra[k*ADDR_W +: ADDR_W];

        // Priority: hardwired zero, then forwarded write data, then stored contents.
        always_comb begin
            rd_dat = regs_q[rd_addr];
            if ((BYPASS != 0) && wr_acc && (rd_addr == dir)) begin
                rd_dat = di;
            end
            if ((ZERO_REG != 0) && (rd_addr == '0)) begin
                rd_dat = '0;
            end
        end

        assign dr[k*DATA_W +: DATA_W] = rd_dat;
    end

endmodule

// File: tb/tb_banco_registros_param.sv
module tb_banco_registros_param;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  ra;
    logic [63:0] dr;
    logic [4:0]  dir;
    logic [31:0] di;
    logic        reg_write;
    logic        clr_req;
    logic        clr_busy;
    logic        clr_done;
    logic        wr_drop;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: register contents plus the clear engine's position.
    logic [31:0] mdl [32];
    bit          m_clearing;   // engine walking the array
    bit          m_done;       // the single cycle after the last register is cleared
    int          m_next;       // next register the engine will clear

    banco_registros_param #(
        .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)
    ) dut (
        .clk(clk), .rst(rst), .ra(ra), .dr(dr), .dir(dir), .di(di),
        .reg_write(reg_write), .clr_req(clr_req), .clr_busy(clr_busy),
        .clr_done(clr_done), .wr_drop(wr_drop)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_accept();
        return reg_write && !m_clearing && (dir != 5'd0);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (m_accept() && a == dir) return di;
        return mdl[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
        m_clearing = 1'b0;
        m_done     = 1'b0;
        m_next     = 0;
    endtask

    // Advance the model with the inputs present now, then let the clock edge happen.
    task automatic cyc();
        bit acc;
        acc = m_accept();
        if (m_clearing) begin
            mdl[m_next] = 32'd0;
            if (m_next == 31) begin
                m_clearing = 1'b0;
                m_done     = 1'b1;
                m_next     = 0;
            end else begin
                m_next++;
            end
        end else if (m_done) begin
            m_done = 1'b0;
            if (acc) mdl[dir] = di;
        end else begin
            if (acc) mdl[dir] = di;
            if (clr_req) begin
                m_clearing = 1'b1;
                m_next     = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_ra(input logic [4:0] a0, input logic [4:0] a1);
        ra = {a1, a0};
        #1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_dr0"},  dr[31:0],  exp_rd(ra[4:0]));
        chk({tag, "_dr1"},  dr[63:32], exp_rd(ra[9:5]));
        chk({tag, "_drop"}, {31'd0, wr_drop}, {31'd0, reg_write && (m_clearing || dir == 5'd0)});
        chk({tag, "_busy"}, {31'd0, clr_busy}, {31'd0, m_clearing});
        chk({tag, "_done"}, {31'd0, clr_done}, {31'd0, m_done});
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        reg_write = 1'b1; dir = a; di = d;
        cyc();
        reg_write = 1'b0;
    endtask

    task automatic sweep_regs(input string tag);
        for (int i = 0; i < 32; i += 2) begin
            set_ra(5'(i), 5'(i + 1));
            chk({tag, "_p0"}, dr[31:0],  mdl[i]);
            chk({tag, "_p1"}, dr[63:32], mdl[i + 1]);
        end
    endtask

    initial begin
        rst = 1'b1; ra = '0; dir = '0; di = '0; reg_write = 1'b0; clr_req = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: reset state
        set_ra(5'd2, 5'd1);
        chk("t1_dr0", dr[31:0], 32'd0);
        chk("t1_dr1", dr[63:32], 32'd0);
        chk("t1_busy", {31'd0, clr_busy}, 32'd0);
        chk("t1_done", {31'd0, clr_done}, 32'd0);
        check_all("t1");

        // 2: successive writes then dual read
        do_write(5'd1, 32'd1);
        do_write(5'd2, 32'd2);
        do_write(5'd3, 32'd3);
        set_ra(5'd3, 5'd2);
        chk("t2_dr0", dr[31:0], 32'd3);
        chk("t2_dr1", dr[63:32], 32'd2);

        // 3: same-cycle bypass, then stored value
        reg_write = 1'b1; dir = 5'd22; di = 32'd458;
        set_ra(5'd22, 5'd1);
        chk("t3_bypass", dr[31:0], 32'd458);
        chk("t3_nodrop", {31'd0, wr_drop}, 32'd0);
        cyc();
        reg_write = 1'b0;
        #1;
        chk("t3_stored", dr[31:0], 32'd458);

        // 4: write to register 0 is dropped
        reg_write = 1'b1; dir = 5'd0; di = 32'd2541;
        set_ra(5'd0, 5'd0);
        chk("t4_drop", {31'd0, wr_drop}, 32'd1);
        chk("t4_nofwd", dr[31:0], 32'd0);
        cyc();
        reg_write = 1'b0;
        #1;
        chk("t4_r0", dr[31:0], 32'd0);

        // 5: bulk clear with a dropped write during busy
        do_write(5'd26, 32'd4541);
        do_write(5'd5, 32'd77);
        set_ra(5'd26, 5'd5);
        chk("t5_pre26", dr[31:0], 32'd4541);
        clr_req = 1'b1;
        cyc();
        clr_req = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (i == 5) begin
                reg_write = 1'b1; dir = 5'd5; di = 32'hDEAD_BEEF;
            end
            set_ra(5'd26, 5'd5);
            chk("t5_busy", {31'd0, clr_busy}, 32'd1);
            if (i == 5) chk("t5_drop", {31'd0, wr_drop}, 32'd1);
            check_all("t5_walk");
            cyc();
            reg_write = 1'b0;
        end
        #1;
        chk("t5_busy_end", {31'd0, clr_busy}, 32'd0);
        chk("t5_done", {31'd0, clr_done}, 32'd1);
        cyc();
        chk("t5_done_once", {31'd0, clr_done}, 32'd0);
        set_ra(5'd26, 5'd5);
        chk("t5_r26", dr[31:0], 32'd0);
        chk("t5_r5", dr[63:32], 32'd0);
        sweep_regs("t5_sweep");

        // Randomised traffic including occasional clear requests
        for (int n = 0; n < 600; n++) begin
            logic [4:0] a0;
            a0        = 5'($urandom_range(0, 31));
            reg_write = 1'($urandom_range(0, 3) != 0);
            dir       = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            di        = $urandom;
            clr_req   = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 3) == 0) a0 = dir;
            set_ra(a0, ($urandom_range(0, 4) == 0) ? a0 : 5'($urandom_range(0, 31)));
            check_all("rnd");
            cyc();
        end
        reg_write = 1'b0; clr_req = 1'b0;
        while (m_clearing || m_done) cyc();
        sweep_regs("rnd_sweep");

        // 6: reset in the middle of a clear
        for (int i = 1; i < 32; i++) do_write(5'(i), $urandom | 32'h1);
        clr_req = 1'b1;
        cyc();
        clr_req = 1'b0;
        repeat (10) cyc();
        chk("t6_busy_pre", {31'd0, clr_busy}, 32'd1);
        rst = 1'b1;
        #1;
        model_reset();
        chk("t6_busy_async", {31'd0, clr_busy}, 32'd0);
        chk("t6_done_async", {31'd0, clr_done}, 32'd0);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_ra(5'd31, 5'd20);
            check_all("t6_after");
            cyc();
        end
        sweep_regs("t6_sweep");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
